// File: rtl/uart_defs.sv
// Shared UART definitions: frame format constants, receiver state encoding
// and the ASCII digit decode used on the receive side.
`timescale 1ns/1ps
package uart_defs;

    localparam int UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT = 1'b1;
    localparam logic [7:0] ASCII_OFFSET = 8'd48;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_e;

    // Undo the transmitter's "+48" digit encoding; wraps modulo 256.
    function automatic logic [7:0] ascii_decode(input logic [7:0] b);
        return b - ASCII_OFFSET;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running terminal-count timer: counts 0..MAX_COUNT-1 while enabled and
// pulses tick_o on the last count, then wraps to 0. clr_i holds it at 0.
`timescale 1ns/1ps
module uart_bit_timer #(
    parameter int unsigned MAX_COUNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);

    logic [W-1:0] count_q;

    assign tick_o = en_i && !clr_i && (count_q == LAST);

    // Count while enabled; wrap on terminal count so back-to-back periods are exact.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at half a bit,
// samples data bits at mid-bit LSB first, checks the stop bit and presents the
// (optionally ASCII-decoded) byte with a one-cycle valid strobe.
`timescale 1ns/1ps
module uart_rx
    import uart_defs::*;
#(
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned F         = 50000000,
    parameter int unsigned ASCII_DEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CPB  = F / BAUD;
    localparam int unsigned HALF = CPB / 2;

    logic       rx_meta_q;
    logic       rx_s_q;
    logic [1:0] fill_q;
    rx_state_e  state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       ferr_q;

    logic half_en;
    logic bit_en;
    logic half_tick;
    logic bit_tick;

    // The synchroniser flops reset high, so right after reset rx_s does not yet
    // reflect the pin. fill_q marks when the pin value has propagated through
    // both flops, so a line held low across reset is not mistaken for idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            fill_q    <= 2'b00;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    // Timers run only in the states that use them and are held at zero
    // otherwise; transitions between timed states happen on a tick, where the
    // counter wraps to zero, so every state is entered with a cleared timer.
    assign half_en = (state_q == ST_START);
    assign bit_en  = (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_bit_timer #(.MAX_COUNT(HALF)) u_half_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!half_en),
        .en_i   (half_en),
        .tick_o (half_tick)
    );

    uart_bit_timer #(.MAX_COUNT(CPB)) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!bit_en),
        .en_i   (bit_en),
        .tick_o (bit_tick)
    );

    // Receive FSM with registered data/valid/frame_err outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (fill_q[1] && rx_s_q == UART_STOP_BIT) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rx_s_q == UART_START_BIT) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_tick) begin
                        if (rx_s_q == UART_START_BIT) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            // Start bit vanished before mid-bit: a glitch.
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (rx_s_q == UART_STOP_BIT) begin
                            data_q  <= (ASCII_DEC != 0) ? ascii_decode(shift_q) : shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_WAIT_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (ASCII decode on and off) share one serial
// line. Expected events are queued when a frame is driven and compared when
// either receiver raises valid or frame_err.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned BAUD = 9600;
    localparam int unsigned F    = 153600;
    localparam int unsigned CPB  = F / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int LAT = int'(HALF + 9 * CPB + 3);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_dec, data_raw;
    logic       valid_dec, valid_raw, ferr_dec, ferr_raw, busy_dec, busy_raw;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] dec;
        logic [7:0] raw;
        logic       ferr;
        int         start_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] tx;
        int         gap;
        logic [7:0] dec;
        logic [7:0] raw;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    logic [7:0] last_dec = 8'h00;
    logic [7:0] last_raw = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.BAUD(BAUD), .F(F), .ASCII_DEC(1)) dut_dec (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data_dec), .valid(valid_dec), .frame_err(ferr_dec), .busy(busy_dec)
    );

    uart_rx #(.BAUD(BAUD), .F(F), .ASCII_DEC(0)) dut_raw (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data_raw), .valid(valid_raw), .frame_err(ferr_raw), .busy(busy_raw)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: every valid or frame_err must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid_dec || valid_raw || ferr_dec || ferr_raw) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: valid=%0b/%0b frame_err=%0b/%0b, want none",
                         valid_dec, valid_raw, ferr_dec, ferr_raw);
            end else begin
                e = sb.pop_front();
                $display("event @%0d: valid=%0b frame_err=%0b data_dec=0x%02h data_raw=0x%02h",
                         cyc, valid_dec, ferr_dec, data_dec, data_raw);
                check("valid_dec", 32'(valid_dec), 32'(!e.ferr));
                check("valid_raw", 32'(valid_raw), 32'(!e.ferr));
                check("ferr_dec", 32'(ferr_dec), 32'(e.ferr));
                check("ferr_raw", 32'(ferr_raw), 32'(e.ferr));
                check("data_dec", 32'(data_dec), 32'(e.dec));
                check("data_raw", 32'(data_raw), 32'(e.raw));
                check("busy_after_stop", 32'(busy_dec), 32'(e.ferr));
                check_range("latency", cyc - e.start_cyc, LAT - 1, LAT + 1);
            end
        end
    end

    // Drive one 8N1 frame; call on a negedge. stop=0 leaves the line low.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic [7:0] ed, input logic [7:0] er);
        exp_t e;
        if (stop) begin
            last_dec = ed;
            last_raw = er;
        end
        e.dec = last_dec;
        e.raw = last_raw;
        e.ferr = !stop;
        e.start_cyc = cyc;
        sb.push_back(e);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < int'(20 * CPB)) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_drain: %0d events pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h35, int'(2 * CPB), 8'h05, 8'h35};
        vecs[1] = '{8'h30, int'(2 * CPB), 8'h00, 8'h30};
        vecs[2] = '{8'h20, int'(2 * CPB), 8'hF0, 8'h20};
        vecs[3] = '{8'h00, int'(2 * CPB), 8'hD0, 8'h00};
        vecs[4] = '{8'hFF, int'(2 * CPB), 8'hCF, 8'hFF};
        vecs[5] = '{8'hA5, int'(2 * CPB), 8'h75, 8'hA5};
        vecs[6] = '{8'h31, 0,             8'h01, 8'h31};
        vecs[7] = '{8'h39, int'(2 * CPB), 8'h09, 8'h39};

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data_dec", 32'(data_dec), 32'h00);
        check("rst_data_raw", 32'(data_raw), 32'h00);
        check("rst_valid", 32'(valid_dec), 32'h0);
        check("rst_ferr", 32'(ferr_dec), 32'h0);
        check("rst_busy", 32'(busy_dec), 32'h1);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check("idle_busy", 32'(busy_dec), 32'h0);

        // Table-driven frames, including a zero-gap back-to-back pair
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].tx, 1'b1, vecs[i].dec, vecs[i].raw);
            repeat (vecs[i].gap) @(negedge clk);
            if (vecs[i].gap != 0) wait_drain("table");
        end
        check("hold_data_dec", 32'(data_dec), 32'h09);

        // Short low pulse: start bit rejected at mid-bit, busy falls again
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy_dec), 32'h1);
        repeat (9) @(negedge clk);
        check("glitch_busy_lo", 32'(busy_dec), 32'h0);
        check("glitch_data", 32'(data_dec), 32'h09);

        // Stop bit low, line then held low: one frame_err, nothing else
        send_frame(8'h41, 1'b0, 8'h00, 8'h00);
        repeat (40 * CPB) @(negedge clk);
        wait_drain("ferr");
        check("ferr_data_kept", 32'(data_dec), 32'h09);
        check("ferr_wait_idle", 32'(busy_dec), 32'h1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("ferr_recover_busy", 32'(busy_dec), 32'h0);
        send_frame(8'h42, 1'b1, 8'h12, 8'h42);
        repeat (2 * CPB) @(negedge clk);
        wait_drain("after_ferr");

        // Reset during data bit 4 of 0x37; the line source resets too and idles
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = vecs[6].tx[i] ^ 1'b0 ? 1'b1 : 1'b0;
            rx = (8'h37 >> i) & 8'h01 ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_dec = 8'h00;
        last_raw = 8'h00;
        check("midrst_data_dec", 32'(data_dec), 32'h00);
        check("midrst_data_raw", 32'(data_raw), 32'h00);
        check("midrst_valid", 32'(valid_dec), 32'h0);
        check("midrst_ferr", 32'(ferr_dec), 32'h0);
        repeat (2 * CPB) @(negedge clk);
        check("midrst_idle", 32'(busy_dec), 32'h0);
        send_frame(8'h38, 1'b1, 8'h08, 8'h38);
        repeat (2 * CPB) @(negedge clk);
        wait_drain("after_midrst");

        // Line held low across reset release: must wait for a genuine high
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_dec = 8'h00;
        last_raw = 8'h00;
        repeat (3 * CPB) @(negedge clk);
        check("lowrst_busy", 32'(busy_dec), 32'h1);
        check("lowrst_busy_raw", 32'(busy_raw), 32'h1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("lowrst_idle", 32'(busy_dec), 32'h0);
        send_frame(8'h30, 1'b1, 8'h00, 8'h30);
        repeat (2 * CPB) @(negedge clk);
        wait_drain("after_lowrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
